// File: rtl/mac_pkg.sv
// Shared widths, MAC pipeline depth and sequencer state encoding for the dot-product block.
package mac_pkg;
  localparam int DWIDTH_DEF  = 16;
  localparam int AWIDTH_DEF  = 10;
  localparam int MAC_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;
endpackage

// File: rtl/dot_seq_if.sv
// Job request, operand-memory address, external-MAC and result handshake bundle of dot_seq.
interface dot_seq_if #(
  parameter int DWIDTH = mac_pkg::DWIDTH_DEF,
  parameter int AWIDTH = mac_pkg::AWIDTH_DEF
);
  logic              req;
  logic [AWIDTH-1:0] len;
  logic [AWIDTH-1:0] base_w;
  logic [AWIDTH-1:0] base_x;
  logic              busy;
  logic [AWIDTH-1:0] w_addr;
  logic [AWIDTH-1:0] x_addr;
  logic              mac_en;
  logic              mac_clr;
  logic [DWIDTH-1:0] mac_result;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;

  modport master (
    output req, len, base_w, base_x, mac_result, out_ready,
    input  busy, w_addr, x_addr, mac_en, mac_clr, out_valid, out_data
  );

  modport slave (
    input  req, len, base_w, base_x, mac_result, out_ready,
    output busy, w_addr, x_addr, mac_en, mac_clr, out_valid, out_data
  );
endinterface

// File: rtl/seq_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement, decrement saturates at zero.
module seq_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/dot_seq.sv
// Dot-product sequencer: issues len operand addresses, drives an external MAC, returns its result.
// Latency len+MAC_LAT+2 cycles (1 for len==0); result held in OUT until out_ready.
module dot_seq
  import mac_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input logic        clk,
  input logic        xrst,
  dot_seq_if.slave   bus
);
  state_e            state_q, state_d;
  logic [AWIDTH-1:0] w_addr_q, w_addr_d;
  logic [AWIDTH-1:0] x_addr_q, x_addr_d;
  logic              mac_en_q, mac_en_d;
  logic              mac_clr_q, mac_clr_d;
  logic              first_q, first_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [AWIDTH-1:0] cnt_val;

  seq_cnt #(.W(AWIDTH)) u_cnt (
    .clk        (clk),
    .xrst       (xrst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    w_addr_d    = '0;
    x_addr_d    = '0;
    first_d     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    // Memory returns data one cycle after the address, so the MAC strobe trails the issue.
    mac_en_d    = (state_q == ISSUE);
    mac_clr_d   = (state_q == ISSUE) && first_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          cnt_load = 1'b1;
          if (bus.len != '0) begin
            cnt_val  = bus.len - AWIDTH'(1);
            w_addr_d = bus.base_w;
            x_addr_d = bus.base_x;
            first_d  = 1'b1;
            state_d  = ISSUE;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            state_d     = OUT;
          end
        end
      end
      ISSUE: begin
        if (cnt_zero) begin
          // Drain spans MAC_LAT+1 cycles: counter runs MAC_LAT down to 0.
          cnt_load = 1'b1;
          cnt_val  = AWIDTH'(MAC_LAT);
          state_d  = DRAIN;
        end else begin
          cnt_dec  = 1'b1;
          w_addr_d = w_addr_q + AWIDTH'(1);
          x_addr_d = x_addr_q + AWIDTH'(1);
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.mac_result;
          state_d     = OUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q     <= IDLE;
      w_addr_q    <= '0;
      x_addr_q    <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_addr_q    <= w_addr_d;
      x_addr_q    <= x_addr_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.w_addr    = w_addr_q;
  assign bus.x_addr    = x_addr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_dot_seq.sv
// Directed bench for dot_seq with 1-cycle-read operand memories and a MAC_LAT-deep MAC model.
module tb_dot_seq;
  localparam int DW = mac_pkg::DWIDTH_DEF;
  localparam int AW = mac_pkg::AWIDTH_DEF;
  localparam int ML = mac_pkg::MAC_LAT_DEF;

  logic clk;
  logic xrst;
  int   total = 0;
  int   bad   = 0;

  dot_seq_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  dot_seq #(.DWIDTH(DW), .AWIDTH(AW), .MAC_LAT(ML)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] w_mem [0:(1<<AW)-1];
  logic [DW-1:0] x_mem [0:(1<<AW)-1];
  logic [DW-1:0] w_rd = '0;
  logic [DW-1:0] x_rd = '0;
  logic [DW-1:0] acc  = '0;
  logic [DW-1:0] pipe [ML-1];
  logic [DW-1:0] prod;

  always @(posedge clk) begin
    w_rd <= w_mem[bus.w_addr];
    x_rd <= x_mem[bus.x_addr];
  end

  assign prod = DW'(w_rd * x_rd);

  // Accumulator is the first MAC stage; the remaining ML-1 stages are output registers.
  always @(posedge clk) begin
    if (bus.mac_en) acc <= bus.mac_clr ? prod : acc + prod;
    pipe[0] <= acc;
    for (int i = 1; i < ML - 1; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.mac_result = pipe[ML-2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts a job at the current negedge (IDLE cycle) and returns at the negedge of the following IDLE cycle.
  task automatic run_job(input string nm, input int ln, input int bw, input int bx,
                         input int exp_data, input int exp_lat);
    int c, n_en, n_clr;
    bit seen, clr_ok, addr_ok;
    logic [AW-1:0] ew, ex;
    bus.req       = 1'b1;
    bus.len       = AW'(ln);
    bus.base_w    = AW'(bw);
    bus.base_x    = AW'(bx);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    c = 1; n_en = 0; n_clr = 0; seen = 0; clr_ok = 1; addr_ok = 1;
    chk({nm, "_busy"}, bus.busy, 1);
    while (!seen && c <= 200) begin
      if (bus.mac_en) begin
        if (bus.mac_clr !== (n_en == 0)) clr_ok = 0;
        n_en++;
      end else if (bus.mac_clr) begin
        clr_ok = 0;
      end
      if (bus.mac_clr) n_clr++;
      ew = (c <= ln) ? AW'(bw + c - 1) : '0;
      ex = (c <= ln) ? AW'(bx + c - 1) : '0;
      if (bus.w_addr !== ew || bus.x_addr !== ex) addr_ok = 0;
      if (bus.out_valid === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk({nm, "_lat"}, c, exp_lat);
    chk({nm, "_data"}, bus.out_data, exp_data);
    chk({nm, "_mac_en_cnt"}, n_en, ln);
    chk({nm, "_mac_clr_cnt"}, n_clr, (ln != 0) ? 1 : 0);
    chk({nm, "_clr_first"}, clr_ok, 1);
    chk({nm, "_addr"}, addr_ok, 1);
    @(negedge clk);
    chk({nm, "_pulse"}, bus.out_valid, 0);
    chk({nm, "_idle"}, bus.busy, 0);
  endtask

  typedef struct {
    int len;
    int bw;
    int bx;
    int exp_data;
    int exp_lat;
  } vec_t;

  vec_t vt [6];

  initial begin
    int c;
    bit stable, seenv;
    vt[0] = '{4, 0,    100, 70, 8};   // 1*5+2*6+3*7+4*8
    vt[1] = '{0, 0,    100, 0,  1};
    vt[2] = '{4, 1022, 200, 11, 8};   // weight addresses wrap 1022,1023,0,1
    vt[3] = '{3, 0,    300, 14, 7};
    vt[4] = '{3, 0,    310, 32, 7};   // back-to-back: must not include the previous 14
    vt[5] = '{1, 0,    100, 5,  5};

    for (int i = 0; i < (1 << AW); i++) begin
      w_mem[i] = '0;
      x_mem[i] = '0;
    end
    w_mem[0] = 1; w_mem[1] = 2; w_mem[2] = 3; w_mem[3] = 4;
    w_mem[1022] = 3; w_mem[1023] = 5;
    x_mem[100] = 5; x_mem[101] = 6; x_mem[102] = 7; x_mem[103] = 8;
    x_mem[200] = 1; x_mem[201] = 1; x_mem[202] = 1; x_mem[203] = 1;
    x_mem[300] = 1; x_mem[301] = 2; x_mem[302] = 3;
    x_mem[310] = 4; x_mem[311] = 5; x_mem[312] = 6;

    xrst = 1'b0;
    bus.req = 1'b0; bus.len = '0; bus.base_w = '0; bus.base_x = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mac_en", bus.mac_en, 0);
    chk("rst_mac_clr", bus.mac_clr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_x_addr", bus.x_addr, 0);
    xrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_job($sformatf("v%0d", i), vt[i].len, vt[i].bw, vt[i].bx, vt[i].exp_data, vt[i].exp_lat);

    // Consumer stalls for 5 cycles; req pulses in OUT must be ignored.
    bus.out_ready = 1'b0;
    bus.req = 1'b1; bus.len = AW'(2); bus.base_w = '0; bus.base_x = AW'(100);
    @(negedge clk);
    bus.req = 1'b0;
    for (c = 0; c < 50 && bus.out_valid !== 1'b1; c++) @(negedge clk);
    chk("stall_valid", bus.out_valid, 1);
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(17)) stable = 0;
      bus.req = (i == 1 || i == 2);
      bus.len = AW'(1);
      @(negedge clk);
    end
    chk("stall_stable", stable, 1);
    chk("stall_data", bus.out_data, 17);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", bus.out_valid, 0);
    @(negedge clk);
    chk("stall_req_ignored", bus.busy, 0);

    // Reset during ISSUE of a len=8 job abandons it.
    bus.req = 1'b1; bus.len = AW'(8); bus.base_w = '0; bus.base_x = AW'(100);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    xrst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_mac_en", bus.mac_en, 0);
    chk("mid_rst_mac_clr", bus.mac_clr, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_w_addr", bus.w_addr, 0);
    chk("mid_rst_x_addr", bus.x_addr, 0);
    xrst = 1'b1;
    seenv = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seenv = 1;
    end
    chk("mid_rst_no_valid", seenv, 0);
    run_job("post_rst", 2, 0, 100, 17, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dot_seq.md
DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 Parameter DWIDTH, default 16, MAC operand/result width in bits.
REQ-002 Parameter AWIDTH, default 10, operand memory address width.
REQ-003 Parameter MAC_LAT, default 2, cycles from mac_en sample to mac_result reflecting that operand.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 xrst  input  1  reset, synchronous, active-low.
REQ-006 req  input  1  start request; sampled only in IDLE.
REQ-007 len  input  AWIDTH  vector length (operand pair count); captured with req.
REQ-008 base_w, base_x  input  AWIDTH each  start addresses of weight and input vectors; captured with req.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 w_addr, x_addr  output  AWIDTH each  operand memory read addresses; memory read latency 1 cycle.
REQ-011 mac_en  output  1  MAC accumulates current memory read data this cycle.
REQ-012 mac_clr  output  1  MAC discards old accumulator; asserted together with first mac_en of a job.
REQ-013 mac_result  input  DWIDTH  accumulator value from external mac.
REQ-014 out_valid  output  1  result available.
REQ-015 out_data  output  DWIDTH  dot-product result.
REQ-016 out_ready  input  1  consumer accepts result when high with out_valid.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, OUT; exactly one active.
REQ-018 IDLE: on req=1, capture len/base_w/base_x; len!=0 -> ISSUE, len==0 -> OUT with out_data=0.
REQ-019 ISSUE: cycle k (k=0..len-1) drives w_addr=base_w+k, x_addr=base_x+k, modulo 2^AWIDTH (wrap-around, no error).
REQ-020 mac_en SHALL be the issue strobe delayed 1 cycle; mac_clr SHALL be high only in cycle of first mac_en.
REQ-021 After address k=len-1, ISSUE -> DRAIN; DRAIN lasts 1+MAC_LAT cycles (memory plus MAC latency).
REQ-022 On DRAIN final cycle, out_data <= mac_result, out_valid <= 1, state -> OUT.
REQ-023 OUT: out_valid and out_data held stable until out_valid&out_ready; then out_valid <= 0, state -> IDLE.
REQ-024 req while busy is ignored; no queuing.
REQ-025 Job latency req-to-out_valid = len+MAC_LAT+2 cycles for len!=0; 1 cycle for len==0.
REQ-026 Back-to-back: req high in the IDLE cycle following handshake starts a new job; no extra bubble.
REQ-027 Accumulation arithmetic belongs to external MAC; dot_seq SHALL pass mac_result unmodified (no truncation/extension).
REQ-028 w_addr/x_addr SHALL be 0 outside ISSUE.

Reset
REQ-029 xrst=0 at a rising edge SHALL force IDLE and busy=0, mac_en=0, mac_clr=0, out_valid=0, out_data=0, w_addr=0, x_addr=0, internal counter=0.
REQ-030 Reset mid-job abandons the job; no out_valid for it after xrst returns high.
REQ-031 No output SHALL depend combinationally on xrst.

Structure
REQ-032 DWIDTH/AWIDTH defaults, MAC_LAT and the FSM state enum SHALL live in shared package mac_pkg.
REQ-033 Element/drain counting SHALL use one sub-module seq_cnt (loadable down-counter with zero flag).
REQ-034 Bench instantiates dot_seq with behavioural 1-cycle-read memories and the existing mac unit.

Verification
REQ-035 len=4, w={1,2,3,4}, x={5,6,7,8}, out_ready=1 -> out_data=70, out_valid at cycle 8 after req, one-cycle pulse.
REQ-036 len=0 -> out_valid next cycle, out_data=0, no mac_en, no mac_clr.
REQ-037 base_w=1022, len=4 (AWIDTH=10) -> w_addr sequence 1022,1023,0,1.
REQ-038 out_ready held 0 for 5 cycles -> out_valid/out_data stable throughout; req pulses during OUT ignored.
REQ-039 xrst=0 in ISSUE cycle 2 of len=8 job -> all outputs 0 next cycle; fresh len=2 job gives correct result, mac_clr on its first mac_en.
REQ-040 Two back-to-back jobs (len=3 results 14 then 32) -> second mac_clr clears prior accumulation; both results correct.
